// File: rtl/uart_gcd_cpu_top.sv
// uart_gcd_cpu_top: UART-fed subtractive GCD node with LED and 7-segment output.
// Define UART_ECHO_EN to echo every received byte back on uart_tx.
module uart_gcd_cpu_top #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] Switch,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic [7:0] LED,
   output logic [6:0] DigiOut1,
   output logic [6:0] DigiOut2,
   output logic [6:0] DigiOut3,
   output logic [6:0] DigiOut4
);
   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] BIT_M1 = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

   typedef enum logic [1:0] {WAIT_A, WAIT_B, COMPUTE, SEND} state_t;
   state_t state, state_nx;

   logic rx_m, rx_s, rx_d, rx_busy, rx_valid;
   logic [CW-1:0] rx_cnt;
   logic [3:0] rx_bit;
   logic [7:0] rx_byte;
   logic tx_busy, tx_start;
   logic [7:0] tx_data;
   logic [9:0] tx_shift;
   logic [CW-1:0] tx_cnt;
   logic [3:0] tx_bit;
   logic [7:0] a, b, x, y, result, gcd_val;
   logic zero, done, send_done;
   logic unused_sw;

   assign unused_sw = ^Switch[7:1];

   // rx_bit: 0 = start, 1..8 = data, 9 = stop
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         {rx_m, rx_s, rx_d} <= 3'b111;
         rx_busy <= 1'b0;
         rx_valid <= 1'b0;
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_byte <= '0;
      end else begin
         rx_m <= uart_rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
         rx_valid <= 1'b0;
         if (!rx_busy) begin
            if (rx_d && !rx_s) begin
               rx_busy <= 1'b1;
               rx_cnt <= HALF_M1;
               rx_bit <= '0;
            end
         end else if (rx_cnt != '0)
            rx_cnt <= rx_cnt - 1'b1;
         else begin
            rx_cnt <= BIT_M1;
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 4'd0 && rx_s)
               rx_busy <= 1'b0;
            else if (rx_bit == 4'd9) begin
               rx_busy <= 1'b0;
               rx_valid <= rx_s;
            end else if (rx_bit != 4'd0)
               rx_byte <= {rx_s, rx_byte[7:1]};
         end
      end

   // Shift register refills with ones so bit 0 idles high
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         tx_busy <= 1'b0;
         tx_shift <= '1;
         tx_cnt <= '0;
         tx_bit <= '0;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_busy <= 1'b1;
            tx_shift <= {1'b1, tx_data, 1'b0};
            tx_cnt <= BIT_M1;
            tx_bit <= '0;
         end
      end else if (tx_cnt != '0)
         tx_cnt <= tx_cnt - 1'b1;
      else begin
         tx_cnt <= BIT_M1;
         tx_bit <= tx_bit + 1'b1;
         tx_shift <= {1'b1, tx_shift[9:1]};
         if (tx_bit == 4'd9)
            tx_busy <= 1'b0;
      end

   assign uart_tx = tx_shift[0];

   assign zero = (x == 8'd0) || (y == 8'd0);
   assign done = zero || (x == y);
   assign gcd_val = zero ? (x | y) : x;

`ifdef UART_ECHO_EN
   logic echo_pend, res_pend;
   logic [7:0] echo_byte;
   // Echo has priority, so the echo of B always precedes the result
   assign tx_start = !tx_busy && (echo_pend || res_pend);
   assign tx_data = echo_pend ? echo_byte : result;
   assign send_done = !res_pend && !tx_busy;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         echo_pend <= 1'b0;
         echo_byte <= '0;
         res_pend <= 1'b0;
      end else begin
         if (rx_valid) begin
            echo_pend <= 1'b1;
            echo_byte <= rx_byte;
         end else if (tx_start && echo_pend)
            echo_pend <= 1'b0;
         if (state == COMPUTE && done)
            res_pend <= 1'b1;
         else if (tx_start && !echo_pend)
            res_pend <= 1'b0;
      end
`else
   assign tx_start = (state == COMPUTE) && done;
   assign tx_data = gcd_val;
   assign send_done = !tx_busy;
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset)
         state <= WAIT_A;
      else
         state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         WAIT_A:  state_nx = rx_valid ? WAIT_B : WAIT_A;
         WAIT_B:  state_nx = rx_valid ? COMPUTE : WAIT_B;
         COMPUTE: state_nx = done ? SEND : COMPUTE;
         SEND:    state_nx = send_done ? WAIT_A : SEND;
         default: state_nx = WAIT_A;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         a <= '0;
         b <= '0;
         x <= '0;
         y <= '0;
         result <= '0;
         LED <= '0;
      end else begin
         if (state == WAIT_A && rx_valid)
            a <= rx_byte;
         if (state == WAIT_B && rx_valid) begin
            b <= rx_byte;
            x <= a;
            y <= rx_byte;
         end
         if (state == COMPUTE) begin
            if (done) begin
               result <= gcd_val;
               LED <= gcd_val;
            end else if (x > y)
               x <= x - y;
            else
               y <= y - x;
         end
      end

   function automatic logic [6:0] seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   assign DigiOut1 = Switch[0] ? 7'h7F : seg(a[7:4]);
   assign DigiOut2 = Switch[0] ? 7'h7F : seg(a[3:0]);
   assign DigiOut3 = Switch[0] ? seg(result[7:4]) : seg(b[7:4]);
   assign DigiOut4 = Switch[0] ? seg(result[3:0]) : seg(b[3:0]);
endmodule

// File: tb/tb_uart_gcd_cpu_top.sv
// tb_uart_gcd_cpu_top: directed bench for uart_gcd_cpu_top at 16 clocks per bit.
// Expects echoed bytes in the TX stream when UART_ECHO_EN is defined.
module tb_uart_gcd_cpu_top;
   localparam int DIV = 16;
`ifdef UART_ECHO_EN
   localparam int NTX = 3;
`else
   localparam int NTX = 1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic uart_rx = 1'b1;
   logic [7:0] Switch = 8'h00;
   logic uart_tx;
   logic [7:0] LED;
   logic [6:0] d1, d2, d3, d4;
   int checks = 0;
   int failures = 0;
   logic [7:0] txq[$];

   always #5 clk = ~clk;

   uart_gcd_cpu_top #(.CLK_FREQ(160), .BAUD(10)) dut (
      .clk(clk), .reset(reset), .Switch(Switch), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .LED(LED), .DigiOut1(d1), .DigiOut2(d2), .DigiOut3(d3), .DigiOut4(d4)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin : mon
      logic [7:0] b;
      forever begin
         @(negedge uart_tx);
         repeat (DIV / 2) @(negedge clk);
         if (uart_tx === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (DIV) @(negedge clk);
            if (uart_tx === 1'b1) txq.push_back(b);
         end
      end
   end

   task automatic send_byte(input logic [7:0] v, input logic stop);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = v[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rx = stop;
      repeat (DIV) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic send_pair(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [7:0] exp);
      int cyc;
      send_byte(av, 1'b1);
      send_byte(bv, 1'b1);
      cyc = 0;
      while (LED !== exp && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_led"}, LED, exp);
      chk({tag, "_latency_le_256"}, {7'd0, cyc <= 256}, 8'd1);
      for (int i = 0; i < 2000 && txq.size() < NTX; i++) @(negedge clk);
      chk({tag, "_tx_count"}, 8'(txq.size()), 8'(NTX));
      chk({tag, "_tx_result"}, txq[NTX-1], exp);
`ifdef UART_ECHO_EN
      chk({tag, "_echo_a"}, txq[0], av);
      chk({tag, "_echo_b"}, txq[1], bv);
`endif
      txq.delete();
      repeat (2 * DIV) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tx", {7'd0, uart_tx}, 8'd1);
      chk("rst_led", LED, 8'h00);
      chk("rst_d1", {1'b0, d1}, 8'h40);
      chk("rst_d2", {1'b0, d2}, 8'h40);
      chk("rst_d3", {1'b0, d3}, 8'h40);
      chk("rst_d4", {1'b0, d4}, 8'h40);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      send_pair("b5_0a", 8'hB5, 8'h0A, 8'h01);
      send_pair("08_0c", 8'h08, 8'h0C, 8'h04);
      chk("op_d1", {1'b0, d1}, 8'h40);
      chk("op_d2", {1'b0, d2}, 8'h00);
      chk("op_d3", {1'b0, d3}, 8'h40);
      chk("op_d4", {1'b0, d4}, 8'h46);

      send_pair("0a_08", 8'h0A, 8'h08, 8'h02);
      Switch = 8'h01;
      @(negedge clk);
      chk("res_d1", {1'b0, d1}, 8'h7F);
      chk("res_d2", {1'b0, d2}, 8'h7F);
      chk("res_d3", {1'b0, d3}, 8'h40);
      chk("res_d4", {1'b0, d4}, 8'h24);
      Switch = 8'h00;

      send_pair("00_07", 8'h00, 8'h07, 8'h07);
      send_pair("00_00", 8'h00, 8'h00, 8'h00);
      send_pair("ff_01", 8'hFF, 8'h01, 8'h01);

      send_byte(8'h33, 1'b0);
      repeat (2 * DIV) @(negedge clk);
      chk("frame_err_no_tx", 8'(txq.size()), 8'd0);
      send_pair("frm_0c_12", 8'h0C, 8'h12, 8'h06);

      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      send_pair("glt_15_23", 8'h15, 8'h23, 8'h07);

      send_byte(8'h01, 1'b1);
      repeat (12 * DIV) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_rst_led", LED, 8'h00);
      chk("mid_rst_d2", {1'b0, d2}, 8'h40);
      chk("mid_rst_tx", {7'd0, uart_tx}, 8'd1);
      reset = 1'b0;
      txq.delete();
      repeat (4) @(negedge clk);
      send_pair("06_09", 8'h06, 8'h09, 8'h03);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_gcd_cpu_top.md
Name: uart_gcd_cpu_top

Overview:
- Top-level compute node for the board.
- Receives 8-bit operands over a UART (8N1), computes the GCD of each operand pair with an iterative subtract engine, and transmits the result byte back over the UART.
- Shows the result on LEDs and the operands or result on four 7-segment digits.
- Sits directly on the board pins: switches, UART, LEDs and segment outputs.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate. Divisor is CLK_FREQ/BAUD = 5208 cycles per bit.

Ports:
- clk  in  1  system clock, 50 MHz, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- Switch  in  8  Switch[0] selects display mode (0 = operands, 1 = result); Switch[7:1] are reserved and ignored.
- uart_rx  in  1  serial input; idle high.
- uart_tx  out  1  serial output; idle high.
- LED  out  8  last GCD result.
- DigiOut1  out  7  digit 1 segments, active-low, bit order gfedcba.
- DigiOut2  out  7  digit 2, same encoding.
- DigiOut3  out  7  digit 3, same encoding.
- DigiOut4  out  7  digit 4, same encoding.

Behaviour:
- Reset values:
  - uart_tx = 1; LED = 0.
  - Operand registers A = 0 and B = 0; result = 0.
  - FSM in WAIT_A; RX and TX idle.
  - Digits show "0000".
- Reset asserted mid-frame or mid-compute aborts everything. The first byte after reset release is operand A.
- RX path:
  - Two-flop synchronizer on uart_rx.
  - A falling edge starts a frame. Sample at half a bit (2604 cycles); if the line is high, abort as a glitch.
  - Then sample 8 data bits LSB-first, one every 5208 cycles at bit centre.
  - Stop bit must be 1; otherwise drop the byte (framing error) and keep the FSM state.
  - Valid byte produces a 1-cycle rx_valid pulse.
- Control FSM states: WAIT_A, WAIT_B, COMPUTE, SEND.
  - WAIT_A: on rx_valid, latch A and go to WAIT_B.
  - WAIT_B: on rx_valid, latch B and go to COMPUTE.
  - COMPUTE: one step per cycle on working registers x, y (initialised from A, B).
    - If x == 0 or y == 0: result = x | y, done.
    - Else if x == y: result = x, done.
    - Else the larger value minus the smaller replaces the larger.
    - Worst case 255 cycles.
    - gcd(0,0) = 0; gcd(0,n) = n.
  - Done: LED <= result on the same edge the FSM enters SEND, and the TX start pulse is issued.
  - SEND: wait for TX idle, then return to WAIT_A.
- Bytes received during COMPUTE or SEND are discarded. Normal compute plus TX finishes before the next frame at 9600 baud.
- TX path:
  - Frame is start bit 0, 8 data bits LSB-first, stop bit 1; each bit lasts 5208 cycles.
  - busy is high from start through the end of the stop bit.
  - A start request while busy is ignored.
- Display:
  - Switch[0] = 0: DigiOut1..4 = hex of A[7:4], A[3:0], B[7:4], B[3:0].
  - Switch[0] = 1: DigiOut1 and DigiOut2 blank (7'h7F); DigiOut3 and DigiOut4 = result[7:4], result[3:0].
  - Combinational decode from registers; no multiplexing.
  - Hex font, active-low: 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10, A = 7'h08, b = 7'h03, C = 7'h46, d = 7'h21, E = 7'h06, F = 7'h0E.

Optional Feature:
- Macro UART_ECHO_EN.
- Defined:
  - Every valid received byte is echoed on uart_tx.
  - A one-entry echo holding register is used; the echo starts when TX is idle.
  - In SEND, the result is transmitted only after a pending echo of B completes, so the echo of B precedes the result.
- Undefined: uart_tx carries only result bytes; no echo logic is synthesised.

Test Plan:
- Reset pulse -> uart_tx = 1, LED = 0, all digits 7'h40; after release, send 0xB5 then 0x0A at 9600 baud -> result gcd(181,10) = 0x01; LED = 0x01; uart_tx emits frame 0x01.
- Send 0x08 then 0x0C -> LED = 0x04; TX byte 0x04. With Switch = 0x00: digits = 0, 8, 0, C (7'h40, 7'h00, 7'h40, 7'h46).
- Send 0x0A then 0x08 -> LED = 0x02, TX byte 0x02. Set Switch = 0x01 -> DigiOut1/2 = 7'h7F, DigiOut3/4 = 7'h40, 7'h24.
- Send 0x00 then 0x07 -> result 0x07; send 0x00 then 0x00 -> result 0x00; send 0xFF then 0x01 -> result 0x01, complete within 256 cycles of B's stop bit.
- Frame with stop bit 0 -> byte dropped, FSM state unchanged. 1000-cycle low glitch on uart_rx -> no byte.
- Assert reset while in WAIT_B after 0x01 -> next pair 0x06, 0x09 yields 0x03. With UART_ECHO_EN: TX sequence is 0x06, 0x09, 0x03.
